// File: rtl/sum_align_buffer_if.sv
// Stream bundle for the partial-sum alignment buffer. The Y word enters on the
// in_* side with a valid/ready handshake. The aligned word leaves on the out_* side.
interface sum_align_buffer_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;

    // Producer of Y values and consumer of the aligned output
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // The delay line itself
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/sum_align_buffer.sv
// Stallable, reconfigurable delay line. It holds the incoming partial sum Y while
// the multiplier works, so that Y reaches the FP adder aligned with A*B.
// Each stage carries a valid tag. The output is taken from the stage selected by
// cur_delay. Before a new delay takes effect, the FSM drains the entries that
// are in flight, so no word leaves with the wrong latency.
module sum_align_buffer #(
    parameter int DATA_W        = 32,
    parameter int MAX_DEPTH     = 16,
    parameter int DEFAULT_DELAY = 14
) (
    input  logic                           clock,
    input  logic                           resetn,
    input  logic                           en,
    input  logic                           flush,
    input  logic                           cfg_load,
    input  logic [$clog2(MAX_DEPTH+1)-1:0] cfg_delay,
    output logic [$clog2(MAX_DEPTH+1)-1:0] cur_delay,
    output logic [$clog2(MAX_DEPTH+1)-1:0] inflight,
    sum_align_buffer_if.slave              bus
);
    localparam int DLY_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic {
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DLY_W-1:0]  pend;
    logic [DLY_W-1:0]  pend_next;
    logic [DLY_W-1:0]  cur_delay_next;
    logic              reconfig;

    logic [MAX_DEPTH:1] vld;
    logic [DATA_W-1:0]  data [1:MAX_DEPTH];

    logic              acc;
    logic              tap_vld;
    logic [DATA_W-1:0] tap_data;

    // A request of 0 becomes 1, and a request deeper than the line becomes MAX_DEPTH
    function automatic logic [DLY_W-1:0] clamp_delay(input logic [DLY_W-1:0] d);
        if (d == '0)
            return DLY_W'(1);
        else if (d > DLY_W'(MAX_DEPTH))
            return DLY_W'(MAX_DEPTH);
        else
            return d;
    endfunction

    assign bus.in_ready = (state == ST_RUN);
    assign acc          = bus.in_valid & bus.in_ready;

    assign tap_vld       = vld[cur_delay];
    assign tap_data      = data[cur_delay];
    assign bus.out_valid = tap_vld;
    assign bus.out_data  = tap_vld ? tap_data : '0;

    // Run/drain sequencing. It only moves on cycles where the pipeline advances
    always_comb begin
        state_next     = state;
        pend_next      = pend;
        cur_delay_next = cur_delay;
        reconfig       = 1'b0;
        if (en) begin
            case (state)
                ST_RUN: begin
                    if (cfg_load) begin
                        pend_next  = clamp_delay(cfg_delay);
                        state_next = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (cfg_load)
                        pend_next = clamp_delay(cfg_delay);
                    if (inflight == '0) begin
                        cur_delay_next = pend_next;
                        reconfig       = 1'b1;
                        state_next     = ST_RUN;
                    end
                end
                default: state_next = ST_RUN;
            endcase
        end
    end

    // Control registers: FSM state, pending/active delay and in-flight count
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_RUN;
            pend      <= DLY_W'(DEFAULT_DELAY);
            cur_delay <= DLY_W'(DEFAULT_DELAY);
            inflight  <= '0;
        end else begin
            state     <= state_next;
            pend      <= pend_next;
            cur_delay <= cur_delay_next;
            if (flush || reconfig)
                inflight <= '0;
            else if (en)
                inflight <= inflight + {{(DLY_W-1){1'b0}}, acc}
                                     - {{(DLY_W-1){1'b0}}, tap_vld};
        end
    end

    // Valid tags shift with the data. A flush or a reconfiguration wipes them all
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vld <= '0;
        end else if (flush || reconfig) begin
            vld <= '0;
        end else if (en) begin
            vld <= {vld[MAX_DEPTH-1:1], acc};
        end
    end

    // Data words shift whenever the pipeline advances. Flush leaves them alone
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int k = 1; k <= MAX_DEPTH; k++)
                data[k] <= '0;
        end else if (en) begin
            data[1] <= bus.in_data;
            for (int k = 2; k <= MAX_DEPTH; k++)
                data[k] <= data[k-1];
        end
    end
endmodule
